// File: rtl/teatris_pkg.sv
// Shared definitions for the TEAtris multi-level control unit: state codes,
// map-select encodings, output bundle and the state-to-output decode.
package teatris_pkg;

   localparam int unsigned ESTADO_W   = 5;
   localparam int unsigned NIVEL_W    = 4;
   localparam int unsigned ERROS_W    = 4;
   localparam int unsigned NIVEIS_MAX = 15;
   localparam int unsigned ERROS_MAX  = 15;

   typedef enum logic [ESTADO_W-1:0] {
      INICIAL         = 5'h00,
      CONFIGURA       = 5'h01,
      CARREGA         = 5'h02,
      MOSTRA          = 5'h03,
      ESPERA          = 5'h04,
      TIMEOUT         = 5'h05,
      REGISTRA        = 5'h06,
      COMPARA         = 5'h07,
      ANALISA         = 5'h08,
      FIM             = 5'h09,
      ANIMA_ACERTO    = 5'h0C,
      ANIMA_ORIG      = 5'h0D,
      ANIMA_ERRO      = 5'h0F,
      ANIMA_ORIG_ERRO = 5'h11,
      NIVEL_UP        = 5'h12,
      PAUSA           = 5'h13
   } estado_t;

   localparam logic [1:0] MAPA_NORMAL = 2'b00;
   localparam logic [1:0] MAPA_ACERTO = 2'b01;
   localparam logic [1:0] MAPA_ERRO   = 2'b11;
   localparam logic [1:0] MAPA_NIVEL  = 2'b10;

   typedef struct packed {
      logic       zera_contador;
      logic       conta_contador;
      logic       enable_memoria;
      logic       registra_jogada;
      logic       zera_jogada;
      logic [1:0] sel_mapa;
      logic       sel_peca;
      logic       mapa_fim;
      logic       game_over;
      logic       vitoria;
   } saidas_t;

   // States timed by the animation timer (pause-capable together with ESPERA)
   function automatic logic eh_animacao(estado_t e);
      return (e == ANIMA_ACERTO) || (e == ANIMA_ORIG) || (e == ANIMA_ERRO) ||
             (e == ANIMA_ORIG_ERRO) || (e == NIVEL_UP);
   endfunction

   // Moore decode; venceu selects the FIM flavour
   function automatic saidas_t decodifica(estado_t e, logic venceu);
      saidas_t s;
      s = '0;
      case (e)
         INICIAL:         begin s.zera_contador = 1'b1; s.zera_jogada = 1'b1; end
         CONFIGURA:       s.zera_contador = 1'b1;
         CARREGA:         s.enable_memoria = 1'b1;
         MOSTRA:          begin s.enable_memoria = 1'b1; s.sel_peca = 1'b1; end
         REGISTRA:        s.registra_jogada = 1'b1;
         ANIMA_ACERTO:    begin s.sel_mapa = MAPA_ACERTO; s.sel_peca = 1'b1; end
         ANIMA_ERRO:      begin s.sel_mapa = MAPA_ERRO; s.sel_peca = 1'b1; end
         ANIMA_ORIG,
         ANIMA_ORIG_ERRO: s.sel_peca = 1'b1;
         ANALISA:         s.conta_contador = 1'b1;
         NIVEL_UP:        begin s.sel_mapa = MAPA_NIVEL; s.zera_contador = 1'b1; end
         TIMEOUT:         begin s.game_over = 1'b1; s.mapa_fim = 1'b1; end
         FIM:             begin
                             s.mapa_fim  = 1'b1;
                             s.game_over = ~venceu;
                             s.vitoria   = venceu;
                          end
         default:         s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/teatris_timer.sv
// Loadable down-counter with enable; expira_c flags count==0.
// Ports: clock, reset (async active-low), carrega/valor load, habilita
// counts down, expira_c combinational expiry flag.
module teatris_timer #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic         habilita,
   input  logic [W-1:0] valor,
   output logic         expira_c
);

   logic [W-1:0] contagem;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         contagem <= '0;
      else if (carrega)
         contagem <= valor;
      else if (habilita && (contagem != '0))
         contagem <= contagem - W'(1);
   end

   assign expira_c = (contagem == '0);

endmodule

// File: rtl/teatris_uc_niveis.sv
// TEAtris multi-level game control unit: Moore FSM driving the datapath,
// with animation / move-timeout timers, error (lives) count and levels.
// Ports: clock, reset (async active-low); start, pausa, fim_sequencia,
// tem_jogada, jogada_ok inputs; datapath controls, sel_mapa, sel_peca,
// mapa_fim, game_over, vitoria, nivel, erros, db_estado outputs.
// Optional: `define TEATRIS_PAUSA_EN enables the pausa toggle (PAUSA state).
module teatris_uc_niveis
   import teatris_pkg::*;
#(
   parameter int unsigned NUM_NIVEIS    = 4,
   parameter int unsigned MAX_ERROS     = 3,
   parameter int unsigned ANIM_CICLOS   = 50000000,
   parameter int unsigned TIMEOUT_BASE  = 250000000,
   parameter int unsigned TIMEOUT_PASSO = 50000000,
   parameter int unsigned TIMEOUT_MIN   = 50000000,
   parameter int unsigned TW            = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         pausa,
   input  logic         fim_sequencia,
   input  logic         tem_jogada,
   input  logic         jogada_ok,
   output logic         zera_contador,
   output logic         conta_contador,
   output logic         enable_memoria,
   output logic         registra_jogada,
   output logic         zera_jogada,
   output logic [1:0]   sel_mapa,
   output logic         sel_peca,
   output logic         mapa_fim,
   output logic         game_over,
   output logic         vitoria,
   output logic [3:0]   nivel,
   output logic [3:0]   erros,
   output logic [4:0]   db_estado
);

   estado_t estado, prox, est_saida;
   saidas_t saidas_q;
   logic    venceu, venceu_prox;
   logic    inc_erros, inc_nivel, zera_jogo;
   logic    pausa_sobe;
   logic    exp_anim_c, exp_jogada_c;
   logic [63:0] desconto, limite;

   // Move-timeout limit for the current level, saturating at TIMEOUT_MIN
   always_comb begin
      desconto = 64'(nivel) * 64'(TIMEOUT_PASSO);
      limite   = (desconto >= 64'(TIMEOUT_BASE)) ? 64'd0 : 64'(TIMEOUT_BASE) - desconto;
      if (limite < 64'(TIMEOUT_MIN))
         limite = 64'(TIMEOUT_MIN);
   end

   // Animation timer reloads on every entry, but not when resuming from pause
   teatris_timer #(.W(TW)) u_timer_anim (
      .clock    (clock),
      .reset    (reset),
      .carrega  (eh_animacao(prox) && (prox != estado) && (estado != PAUSA)),
      .habilita (eh_animacao(estado)),
      .valor    (TW'(ANIM_CICLOS - 1)),
      .expira_c (exp_anim_c)
   );

   teatris_timer #(.W(TW)) u_timer_jogada (
      .clock    (clock),
      .reset    (reset),
      .carrega  (estado == MOSTRA),
      .habilita (estado == ESPERA),
      .valor    (TW'(limite - 64'd1)),
      .expira_c (exp_jogada_c)
   );

`ifdef TEATRIS_PAUSA_EN
   logic    pausa_q;
   estado_t salvo;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pausa_q <= 1'b0;
         salvo   <= INICIAL;
      end else begin
         pausa_q <= pausa;
         if ((prox == PAUSA) && (estado != PAUSA))
            salvo <= estado;
      end
   end

   assign pausa_sobe = pausa & ~pausa_q;
   // While paused the outputs mirror the interrupted state
   assign est_saida  = (prox != PAUSA) ? prox : ((estado == PAUSA) ? salvo : estado);
`else
   logic unused_pausa;
   assign unused_pausa = pausa;
   assign pausa_sobe   = 1'b0;
   assign est_saida    = prox;
`endif

   // Next-state logic
   always_comb begin
      prox        = estado;
      inc_erros   = 1'b0;
      inc_nivel   = 1'b0;
      zera_jogo   = 1'b0;
      venceu_prox = venceu;
      case (estado)
         INICIAL: begin
            zera_jogo   = 1'b1;
            venceu_prox = 1'b0;
            if (start) prox = CONFIGURA;
         end
         CONFIGURA: prox = CARREGA;
         CARREGA:   prox = MOSTRA;
         MOSTRA:    prox = ESPERA;
         ESPERA: begin
            if (exp_jogada_c)    prox = TIMEOUT;
            else if (pausa_sobe) prox = PAUSA;
            else if (tem_jogada) prox = REGISTRA;
         end
         REGISTRA: prox = COMPARA;
         COMPARA: begin
            if (jogada_ok) prox = ANIMA_ACERTO;
            else begin
               prox      = ANIMA_ERRO;
               inc_erros = 1'b1;
            end
         end
         ANIMA_ACERTO: begin
            if (exp_anim_c)      prox = ANIMA_ORIG;
            else if (pausa_sobe) prox = PAUSA;
         end
         ANIMA_ORIG: begin
            if (exp_anim_c)      prox = ANALISA;
            else if (pausa_sobe) prox = PAUSA;
         end
         ANIMA_ERRO: begin
            if (exp_anim_c)      prox = ANIMA_ORIG_ERRO;
            else if (pausa_sobe) prox = PAUSA;
         end
         ANIMA_ORIG_ERRO: begin
            if (exp_anim_c) begin
               if (erros == ERROS_W'(MAX_ERROS)) begin
                  prox        = FIM;
                  venceu_prox = 1'b0;
               end else
                  prox = ANALISA;
            end else if (pausa_sobe)
               prox = PAUSA;
         end
         ANALISA: begin
            if (!fim_sequencia)
               prox = CARREGA;
            else if (nivel < NIVEL_W'(NUM_NIVEIS - 1))
               prox = NIVEL_UP;
            else begin
               prox        = FIM;
               venceu_prox = 1'b1;
            end
         end
         NIVEL_UP: begin
            if (exp_anim_c) begin
               prox      = CARREGA;
               inc_nivel = 1'b1;
            end else if (pausa_sobe)
               prox = PAUSA;
         end
         TIMEOUT, FIM: if (start) prox = INICIAL;
`ifdef TEATRIS_PAUSA_EN
         PAUSA: if (pausa_sobe) prox = salvo;
`endif
         default: prox = INICIAL;
      endcase
   end

   // State, game registers and registered output decode
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= INICIAL;
         nivel    <= '0;
         erros    <= '0;
         venceu   <= 1'b0;
         saidas_q <= decodifica(INICIAL, 1'b0);
      end else begin
         estado   <= prox;
         venceu   <= venceu_prox;
         saidas_q <= decodifica(est_saida, venceu_prox);
         if (zera_jogo)      nivel <= '0;
         else if (inc_nivel) nivel <= nivel + NIVEL_W'(1);
         if (zera_jogo)      erros <= '0;
         else if (inc_erros) erros <= erros + ERROS_W'(1);
      end
   end

   assign zera_contador   = saidas_q.zera_contador;
   assign conta_contador  = saidas_q.conta_contador;
   assign enable_memoria  = saidas_q.enable_memoria;
   assign registra_jogada = saidas_q.registra_jogada;
   assign zera_jogada     = saidas_q.zera_jogada;
   assign sel_mapa        = saidas_q.sel_mapa;
   assign sel_peca        = saidas_q.sel_peca;
   assign mapa_fim        = saidas_q.mapa_fim;
   assign game_over       = saidas_q.game_over;
   assign vitoria         = saidas_q.vitoria;
   assign db_estado       = estado;

endmodule

// File: tb/tb_teatris_uc_niveis.sv
// Self-checking bench for teatris_uc_niveis: directed games followed by
// randomized moves, checked against a move-level model of the game rules.
module tb_teatris_uc_niveis;

   localparam int ANIM = 4;
   localparam int TB   = 20;
   localparam int TP   = 5;
   localparam int TM   = 8;
   localparam int NN   = 2;
   localparam int ME   = 2;

   logic       clock = 1'b0;
   logic       reset, start, pausa, fim_sequencia, tem_jogada, jogada_ok;
   logic       zera_contador, conta_contador, enable_memoria, registra_jogada, zera_jogada;
   logic [1:0] sel_mapa;
   logic       sel_peca, mapa_fim, game_over, vitoria;
   logic [3:0] nivel, erros;
   logic [4:0] db_estado;

   int checks = 0;
   int errors = 0;
   int m_nivel = 0;
   int m_erros = 0;

   teatris_uc_niveis #(
      .NUM_NIVEIS(NN), .MAX_ERROS(ME), .ANIM_CICLOS(ANIM),
      .TIMEOUT_BASE(TB), .TIMEOUT_PASSO(TP), .TIMEOUT_MIN(TM), .TW(8)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .pausa(pausa),
      .fim_sequencia(fim_sequencia), .tem_jogada(tem_jogada), .jogada_ok(jogada_ok),
      .zera_contador(zera_contador), .conta_contador(conta_contador),
      .enable_memoria(enable_memoria), .registra_jogada(registra_jogada),
      .zera_jogada(zera_jogada), .sel_mapa(sel_mapa), .sel_peca(sel_peca),
      .mapa_fim(mapa_fim), .game_over(game_over), .vitoria(vitoria),
      .nivel(nivel), .erros(erros), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Move timeout in cycles for a level
   function automatic int lim(input int n);
      int v;
      v = TB - n * TP;
      if (v < TM) v = TM;
      return v;
   endfunction

   task automatic corrida(input string tag, input logic [4:0] code, input logic [1:0] sel);
      for (int i = 0; i < ANIM; i++) begin
         verifica(tag, db_estado, code);
         verifica("anim_sel_mapa", sel_mapa, sel);
         verifica("anim_sel_peca", sel_peca, 1);
         verifica("anim_erros", erros, m_erros);
         @(negedge clock);
      end
   endtask

   task automatic carrega_mostra();
      verifica("carrega", db_estado, 5'h02);
      verifica("carrega_mem", enable_memoria, 1);
      verifica("nivel", nivel, m_nivel);
      @(negedge clock);
      verifica("mostra", db_estado, 5'h03);
      verifica("mostra_peca", sel_peca, 1);
      @(negedge clock);
   endtask

   task automatic inicia_jogo();
      verifica("inicial", db_estado, 5'h00);
      verifica("inicial_zera", zera_jogada, 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      m_nivel = 0;
      m_erros = 0;
      verifica("configura", db_estado, 5'h01);
      verifica("configura_zera", zera_contador, 1);
      verifica("novo_nivel", nivel, 0);
      verifica("novo_erros", erros, 0);
      @(negedge clock);
      carrega_mostra();
   endtask

   // End screen holds until start, then back to INICIAL
   task automatic termina(input logic [4:0] code);
      @(negedge clock);
      verifica("fim_mantem", db_estado, code);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      verifica("volta_inicial", db_estado, 5'h00);
      verifica("volta_zera_cont", zera_contador, 1);
   endtask

   // One move from the first ESPERA cycle; acabou set when the game ended
   task automatic jogada(input int delay, input bit ok, input bit fim,
                         input int pause_at, input bit ruido, output bit acabou);
      int L, k, exp_k;
      bit to;
      L = lim(m_nivel);
      k = 0;
      acabou = 1'b0;
      jogada_ok = ok;
      verifica("espera", db_estado, 5'h04);
      verifica("espera_nivel", nivel, m_nivel);
      while (db_estado == 5'h04 && k < 200) begin
         k++;
         tem_jogada = (k == delay + 1);
         if (ruido) start = 1'($urandom_range(0, 1));
`ifdef TEATRIS_PAUSA_EN
         if (pause_at != 0 && k == pause_at) begin
            pausa = 1'b1;
            @(negedge clock);
            pausa = 1'b0;
            for (int p = 0; p < 100; p++) begin
               verifica("pausa", db_estado, 5'h13);
               verifica("pausa_mapa", sel_mapa, 0);
               verifica("pausa_fim", mapa_fim, 0);
               tem_jogada = (p == 50);
               if (p == 99) pausa = 1'b1;
               @(negedge clock);
            end
            pausa = 1'b0;
            tem_jogada = 1'b0;
            continue;
         end
`else
         if (pause_at != 0 || ruido) pausa = 1'($urandom_range(0, 1));
`endif
         @(negedge clock);
      end
      tem_jogada = 1'b0;
      start = 1'b0;
      pausa = 1'b0;
      to = (delay + 1 >= L);
      exp_k = to ? L : delay + 1;
      verifica("espera_ciclos", k, exp_k);
      if (to) begin
         verifica("timeout", db_estado, 5'h05);
         verifica("timeout_go", game_over, 1);
         verifica("timeout_mapa", mapa_fim, 1);
         verifica("timeout_vit", vitoria, 0);
         termina(5'h05);
         acabou = 1'b1;
         return;
      end
      verifica("registra", db_estado, 5'h06);
      verifica("registra_jog", registra_jogada, 1);
      @(negedge clock);
      verifica("compara", db_estado, 5'h07);
      @(negedge clock);
      if (ok) begin
         corrida("acerto", 5'h0C, 2'b01);
         corrida("orig", 5'h0D, 2'b00);
      end else begin
         m_erros++;
         corrida("erro", 5'h0F, 2'b11);
         corrida("orig_erro", 5'h11, 2'b00);
         if (m_erros == ME) begin
            verifica("perdeu", db_estado, 5'h09);
            verifica("perdeu_go", game_over, 1);
            verifica("perdeu_vit", vitoria, 0);
            verifica("perdeu_erros", erros, ME);
            termina(5'h09);
            acabou = 1'b1;
            return;
         end
      end
      verifica("analisa", db_estado, 5'h08);
      verifica("analisa_conta", conta_contador, 1);
      fim_sequencia = fim;
      @(negedge clock);
      fim_sequencia = 1'b0;
      if (!fim) begin
         carrega_mostra();
      end else if (m_nivel < NN - 1) begin
         for (int i = 0; i < ANIM; i++) begin
            verifica("nivel_up", db_estado, 5'h12);
            verifica("nivel_up_mapa", sel_mapa, 2'b10);
            verifica("nivel_up_zera", zera_contador, 1);
            @(negedge clock);
         end
         m_nivel++;
         carrega_mostra();
      end else begin
         verifica("venceu", db_estado, 5'h09);
         verifica("venceu_vit", vitoria, 1);
         verifica("venceu_go", game_over, 0);
         verifica("venceu_mapa", mapa_fim, 1);
         termina(5'h09);
         acabou = 1'b1;
      end
   endtask

   int dl[9]  = '{3, 19, 1, 0, 2, 30, 0, 5, 40};
   bit okv[9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
   bit fv[9]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
   int pv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 10};

   initial begin
      bit acabou;
      int L, sel, d;
      reset = 1'b0; start = 1'b0; pausa = 1'b0;
      fim_sequencia = 1'b0; tem_jogada = 1'b0; jogada_ok = 1'b0;
      repeat (3) @(negedge clock);
      verifica("rst_estado", db_estado, 5'h00);
      verifica("rst_zera_cont", zera_contador, 1);
      verifica("rst_zera_jog", zera_jogada, 1);
      verifica("rst_outros", {conta_contador, enable_memoria, registra_jogada,
                              sel_mapa, sel_peca, mapa_fim, game_over, vitoria}, 0);
      verifica("rst_nivel", nivel, 0);
      reset = 1'b1;
      @(negedge clock);

      // Asynchronous reset in the middle of ANIMA_ACERTO
      inicia_jogo();
      jogada_ok = 1'b1;
      tem_jogada = 1'b1;
      @(negedge clock);
      tem_jogada = 1'b0;
      verifica("r_registra", db_estado, 5'h06);
      @(negedge clock);
      @(negedge clock);
      verifica("r_acerto", db_estado, 5'h0C);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      verifica("arst_estado", db_estado, 5'h00);
      verifica("arst_nivel", nivel, 0);
      verifica("arst_erros", erros, 0);
      verifica("arst_mapa", sel_mapa, 0);
      verifica("arst_zera", zera_contador, 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      inicia_jogo();
      for (int i = 0; i < 9; i++) begin
         jogada(dl[i], okv[i], fv[i], pv[i], 1'b0, acabou);
         if (acabou) inicia_jogo();
      end

      for (int i = 0; i < 60; i++) begin
         L = lim(m_nivel);
         sel = $urandom_range(0, 3);
         if (sel <= 1)      d = $urandom_range(0, 6);
         else if (sel == 2) d = $urandom_range(L - 2, L + 1);
         else               d = $urandom_range(0, 40);
         jogada(d, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 0, 1'b1, acabou);
         if (acabou) inicia_jogo();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
